serial_add_unit: RTL and testbench



---
 rtl/serial_add_unit.sv | 132 +++++++++++++
 tb/tb_serial_add_unit.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/serial_add_unit.sv
// rtl/serial_add_unit.sv - bit-serial adder, one full-adder cell per clock, valid/ready in and out
// Optional signed-overflow output ovf is built when SERIAL_ADD_OVF_EN is defined.
module serial_add_unit #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
`ifdef SERIAL_ADD_OVF_EN
  output logic             ovf,
`endif
  output logic             busy
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {IDLE, RUN, HOLD} state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_sr_q, a_sr_d;
  logic [WIDTH-1:0] b_sr_q, b_sr_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             carry_q, carry_d;
  logic             cout_q, cout_d;
  logic             accept, last_bit, bit_s, bit_c;

  assign accept   = in_valid && in_ready;
  assign last_bit = (state_q == RUN) && (cnt_q == CW'(WIDTH - 1));
  assign bit_s    = a_sr_q[0] ^ b_sr_q[0] ^ carry_q;
  assign bit_c    = (a_sr_q[0] & b_sr_q[0]) | (a_sr_q[0] & carry_q) | (b_sr_q[0] & carry_q);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (accept) state_d = RUN;
      RUN:     if (last_bit) state_d = HOLD;
      HOLD:    if (out_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    in_ready  = (state_q == IDLE);
    busy      = (state_q == RUN);
    out_valid = (state_q == HOLD);
  end

  // Datapath: sum fills from the MSB end so after WIDTH shifts bit 0 holds the LSB result.
  always_comb begin
    a_sr_d  = a_sr_q;
    b_sr_d  = b_sr_q;
    sum_d   = sum_q;
    cnt_d   = cnt_q;
    carry_d = carry_q;
    cout_d  = cout_q;
    if (state_q == IDLE && accept) begin
      a_sr_d  = a;
      b_sr_d  = b;
      carry_d = cin;
      cnt_d   = '0;
    end else if (state_q == RUN) begin
      a_sr_d  = a_sr_q >> 1;
      b_sr_d  = b_sr_q >> 1;
      sum_d   = {bit_s, sum_q[WIDTH-1:1]};
      carry_d = bit_c;
      if (last_bit) begin
        cout_d = bit_c;
      end else begin
        cnt_d = cnt_q + CW'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_sr_q  <= '0;
      b_sr_q  <= '0;
      sum_q   <= '0;
      cnt_q   <= '0;
      carry_q <= 1'b0;
      cout_q  <= 1'b0;
    end else begin
      a_sr_q  <= a_sr_d;
      b_sr_q  <= b_sr_d;
      sum_q   <= sum_d;
      cnt_q   <= cnt_d;
      carry_q <= carry_d;
      cout_q  <= cout_d;
    end
  end

  assign sum  = sum_q;
  assign cout = cout_q;

`ifdef SERIAL_ADD_OVF_EN
  logic ovf_q, ovf_d;

  // On the final bit carry_q is the carry into the MSB and bit_c the carry out of it.
  always_comb begin
    ovf_d = ovf_q;
    if (last_bit) ovf_d = carry_q ^ bit_c;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ovf_q <= 1'b0;
    end else begin
      ovf_q <= ovf_d;
    end
  end

  assign ovf = ovf_q;
`endif

endmodule

// File: tb/tb_serial_add_unit.sv
// tb/tb_serial_add_unit.sv - self-checking bench for serial_add_unit
// Directed and random transactions compared with an arithmetic reference model.
module tb_serial_add_unit;

  localparam int WIDTH = 8;

  logic             clk;
  logic             rst_n;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] sum;
  logic             cout;
  logic             busy;
`ifdef SERIAL_ADD_OVF_EN
  logic             ovf;
`endif

  int n_checks;
  int n_fail;

  serial_add_unit #(.WIDTH(WIDTH)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .cin       (cin),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sum       (sum),
    .cout      (cout),
`ifdef SERIAL_ADD_OVF_EN
    .ovf       (ovf),
`endif
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  // Reference: a+b+cin as plain integer arithmetic; ovf from operand/result sign bits.
  task automatic model(input logic [WIDTH-1:0] ma, input logic [WIDTH-1:0] mb, input logic mc,
                       output logic [WIDTH-1:0] es, output logic ec, output logic eo);
    int unsigned full;
    full = int'(ma) + int'(mb) + int'(mc);
    es   = full[WIDTH-1:0];
    ec   = full[WIDTH];
    eo   = (ma[WIDTH-1] == mb[WIDTH-1]) && (es[WIDTH-1] != ma[WIDTH-1]);
  endtask

  task automatic wait_result(input string tag, output int lat);
    lat = 0;
    do begin
      tick();
      lat++;
      if (!out_valid) begin
        check({tag, "_busy"}, {31'b0, busy}, 32'd1);
        check({tag, "_in_ready_run"}, {31'b0, in_ready}, 32'd0);
      end
    end while (!out_valid && lat < WIDTH + 4);
  endtask

  task automatic check_result(input string tag, input logic [WIDTH-1:0] ta,
                              input logic [WIDTH-1:0] tb, input logic tc);
    logic [WIDTH-1:0] es;
    logic ec, eo;
    model(ta, tb, tc, es, ec, eo);
    check({tag, "_out_valid"}, {31'b0, out_valid}, 32'd1);
    check({tag, "_sum"}, 32'(sum), 32'(es));
    check({tag, "_cout"}, {31'b0, cout}, {31'b0, ec});
`ifdef SERIAL_ADD_OVF_EN
    check({tag, "_ovf"}, {31'b0, ovf}, {31'b0, eo});
`endif
  endtask

  task automatic do_txn(input string tag, input logic [WIDTH-1:0] ta, input logic [WIDTH-1:0] tb,
                        input logic tc, input int hold);
    int lat;
    a = ta; b = tb; cin = tc; in_valid = 1'b1;
    out_ready = (hold == 0);
    check({tag, "_in_ready_idle"}, {31'b0, in_ready}, 32'd1);
    tick();
    in_valid = 1'b0;
    a = WIDTH'($urandom); b = WIDTH'($urandom); cin = 1'($urandom);
    wait_result(tag, lat);
    check({tag, "_latency"}, 32'(lat), 32'(WIDTH));
    check_result(tag, ta, tb, tc);
    for (int h = 0; h < hold; h++) begin
      tick();
      check_result({tag, "_hold"}, ta, tb, tc);
      check({tag, "_in_ready_hold"}, {31'b0, in_ready}, 32'd0);
    end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check({tag, "_out_valid_after"}, {31'b0, out_valid}, 32'd0);
    check({tag, "_in_ready_after"}, {31'b0, in_ready}, 32'd1);
  endtask

  initial begin
    int lat;
    int seen;
    n_checks = 0; n_fail = 0;
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    a = '0; b = '0; cin = 1'b0;
    tick();
    check("rst_in_ready", {31'b0, in_ready}, 32'd1);
    check("rst_out_valid", {31'b0, out_valid}, 32'd0);
    check("rst_busy", {31'b0, busy}, 32'd0);
    check("rst_sum", 32'(sum), 32'd0);
    check("rst_cout", {31'b0, cout}, 32'd0);
`ifdef SERIAL_ADD_OVF_EN
    check("rst_ovf", {31'b0, ovf}, 32'd0);
`endif
    rst_n = 1'b1;
    tick();

    do_txn("t0f_01", 8'h0F, 8'h01, 1'b0, 0);
    do_txn("tff_01", 8'hFF, 8'h01, 1'b0, 0);
    do_txn("tff_ff_c", 8'hFF, 8'hFF, 1'b1, 0);
    do_txn("t12_34_hold", 8'h12, 8'h34, 1'b0, 5);
    do_txn("t7f_01", 8'h7F, 8'h01, 1'b0, 1);

    // Asynchronous reset in the middle of RUN.
    a = 8'hAA; b = 8'h55; cin = 1'b0; in_valid = 1'b1; out_ready = 1'b1;
    tick();
    in_valid = 1'b0;
    tick(); tick(); tick();
    #2 rst_n = 1'b0;
    #1;
    check("arst_busy", {31'b0, busy}, 32'd0);
    check("arst_in_ready", {31'b0, in_ready}, 32'd1);
    check("arst_sum", 32'(sum), 32'd0);
    check("arst_cout", {31'b0, cout}, 32'd0);
    #1 rst_n = 1'b1;
    seen = 0;
    for (int i = 0; i < WIDTH + 4; i++) begin
      tick();
      if (out_valid) seen++;
    end
    check("arst_no_out_valid", 32'(seen), 32'd0);
    do_txn("t01_01", 8'h01, 8'h01, 1'b0, 0);

    // Back-to-back: in_valid stays high, second pair must wait for the handoff.
    a = 8'h03; b = 8'h04; cin = 1'b0; in_valid = 1'b1; out_ready = 1'b1;
    check("b2b_in_ready0", {31'b0, in_ready}, 32'd1);
    tick();
    a = 8'h10; b = 8'h20;
    wait_result("b2b_first", lat);
    check("b2b_lat0", 32'(lat), 32'(WIDTH));
    check_result("b2b_first", 8'h03, 8'h04, 1'b0);
    tick();
    check("b2b_gap_in_ready", {31'b0, in_ready}, 32'd1);
    check("b2b_gap_busy", {31'b0, busy}, 32'd0);
    check("b2b_gap_out_valid", {31'b0, out_valid}, 32'd0);
    tick();
    in_valid = 1'b0;
    wait_result("b2b_second", lat);
    check("b2b_lat1", 32'(lat), 32'(WIDTH));
    check_result("b2b_second", 8'h10, 8'h20, 1'b0);
    tick();
    out_ready = 1'b0;

    for (int i = 0; i < 20; i++) begin
      do_txn($sformatf("rnd%0d", i), WIDTH'($urandom), WIDTH'($urandom), 1'($urandom),
             int'($urandom_range(0, 3)));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
